// File: rtl/modem_pkg.sv
// rtl/modem_pkg.sv - shared constants, register map and sequencer state encoding
package modem_pkg;

  localparam int          DATA_W        = 8;
  localparam int          MSG_MAX       = 1000;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [15:0] SYNC_WORD     = 16'h2DD4;

  // Register block address map
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_LEN    = 8'h08;
  localparam logic [7:0] REG_DATA   = 8'h0C;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_SYNC,
    ST_LEN,
    ST_FETCH,
    ST_WAIT,
    ST_PRESENT,
    ST_DONE,
    ST_ARM
  } seq_state_e;

endpackage

// File: rtl/tx_frame_sequencer_if.sv
// rtl/tx_frame_sequencer_if.sv - byte stream from the sequencer to the modulator
interface tx_frame_sequencer_if;
  import modem_pkg::*;

  logic [DATA_W-1:0] o_byte;
  logic              o_byte_valid;
  logic              i_byte_ready;

  modport master (output o_byte, output o_byte_valid, input i_byte_ready);
  modport slave  (input o_byte, input o_byte_valid, output i_byte_ready);

endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - single RAM port mux: idle host write > host read > sequencer fetch
module ram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busy_i,
  input  logic              drop_clr_i,
  input  logic              host_rd_i,
  input  logic              host_wr_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic [DATA_W-1:0] host_rdata_o,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_gnt_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              wr_dropped_o
);

  logic              rd_acc;
  logic              rd_pend_q;
  logic [DATA_W-1:0] rdata_q;
  logic              drop_q;

  // A write during a frame never reaches the port, so it cannot stall the fetch
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    fetch_gnt_o = 1'b0;
    rd_acc      = 1'b0;
    if (host_wr_i && !busy_i) begin
      ram_en_o    = 1'b1;
      ram_we_o    = 1'b1;
      ram_addr_o  = host_addr_i;
      ram_wdata_o = host_wdata_i;
    end else if (host_rd_i) begin
      ram_en_o   = 1'b1;
      ram_addr_o = host_addr_i;
      rd_acc     = 1'b1;
    end else if (fetch_req_i) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = fetch_addr_i;
      fetch_gnt_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rdata_q   <= '0;
      drop_q    <= 1'b0;
    end else begin
      rd_pend_q <= rd_acc;
      if (rd_pend_q) rdata_q <= ram_rdata_i;
      if (host_wr_i && busy_i) drop_q <= 1'b1;
      else if (drop_clr_i)     drop_q <= 1'b0;
    end
  end

  // RAM data is live in the cycle after the read; the register keeps it afterwards
  assign host_rdata_o = rd_pend_q ? ram_rdata_i : rdata_q;
  assign wr_dropped_o = drop_q;

endmodule

// File: rtl/tx_frame_sequencer.sv
// rtl/tx_frame_sequencer.sv - frame builder: preamble, sync, length, payload from message RAM
module tx_frame_sequencer #(
  parameter int          ADDR_W        = 10,
  parameter int          DATA_W        = modem_pkg::DATA_W,
  parameter int          MSG_MAX       = modem_pkg::MSG_MAX,
  parameter int          PREAMBLE_LEN  = 4,
  parameter logic [7:0]  PREAMBLE_BYTE = modem_pkg::PREAMBLE_BYTE,
  parameter logic [15:0] SYNC_WORD     = modem_pkg::SYNC_WORD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [ADDR_W-1:0]     i_msg_length,
  input  logic                  i_host_rd,
  input  logic                  i_host_wr,
  input  logic [ADDR_W-1:0]     i_host_addr,
  input  logic [DATA_W-1:0]     i_host_wdata,
  output logic [DATA_W-1:0]     o_host_rdata,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_W-1:0]     o_ram_addr,
  output logic [DATA_W-1:0]     o_ram_wdata,
  input  logic [DATA_W-1:0]     i_ram_rdata,
  tx_frame_sequencer_if.master  tx,
  output logic                  o_busy,
  output logic                  o_tx_done,
  output logic                  o_wr_dropped
);
  import modem_pkg::*;

  localparam logic [ADDR_W-1:0] MSG_MAX_W = ADDR_W'(MSG_MAX);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              start_q;
  logic              start_edge, accept, fetch_req, fetch_gnt, drop_clr;

  assign start_edge = i_start && !start_q;
  assign accept     = valid_q && tx.i_byte_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      start_q <= i_start;
    end
  end

  // Header bytes are loaded on the accepting edge so they stream without gaps
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    fetch_req = 1'b0;
    drop_clr  = 1'b0;
    case (state_q)
      ST_IDLE: if (start_edge) begin
        len_d    = (i_msg_length > MSG_MAX_W) ? MSG_MAX_W : i_msg_length;
        ptr_d    = '0;
        cnt_d    = '0;
        byte_d   = PREAMBLE_BYTE;
        valid_d  = 1'b1;
        drop_clr = 1'b1;
        state_d  = ST_PRE;
      end
      ST_PRE: if (accept) begin
        if (cnt_q == 8'(PREAMBLE_LEN - 1)) begin
          byte_d  = SYNC_WORD[15:8];
          cnt_d   = '0;
          state_d = ST_SYNC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SYNC: if (accept) begin
        if (cnt_q == 8'd0) begin
          byte_d = SYNC_WORD[7:0];
          cnt_d  = 8'd1;
        end else begin
          byte_d  = DATA_W'(len_q >> DATA_W);
          cnt_d   = '0;
          state_d = ST_LEN;
        end
      end
      ST_LEN: if (accept) begin
        if (cnt_q == 8'd0) begin
          byte_d = DATA_W'(len_q);
          cnt_d  = 8'd1;
        end else begin
          valid_d = 1'b0;
          state_d = (len_q == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        byte_d  = i_ram_rdata;
        valid_d = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: if (accept) begin
        valid_d = 1'b0;
        state_d = (ptr_q < len_q) ? ST_FETCH : ST_DONE;
      end
      ST_DONE: state_d = ST_ARM;
      ST_ARM:  if (!i_start) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy          = (state_q != ST_IDLE) && (state_q != ST_ARM);
  assign o_tx_done       = (state_q == ST_DONE);
  assign tx.o_byte       = byte_q;
  assign tx.o_byte_valid = valid_q;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_arb (
    .clk          (clk),
    .reset        (reset),
    .busy_i       (o_busy),
    .drop_clr_i   (drop_clr),
    .host_rd_i    (i_host_rd),
    .host_wr_i    (i_host_wr),
    .host_addr_i  (i_host_addr),
    .host_wdata_i (i_host_wdata),
    .host_rdata_o (o_host_rdata),
    .fetch_req_i  (fetch_req),
    .fetch_addr_i (ptr_q),
    .fetch_gnt_o  (fetch_gnt),
    .ram_en_o     (o_ram_en),
    .ram_we_o     (o_ram_we),
    .ram_addr_o   (o_ram_addr),
    .ram_wdata_o  (o_ram_wdata),
    .ram_rdata_i  (i_ram_rdata),
    .wr_dropped_o (o_wr_dropped)
  );

endmodule
